pipelined_adder_tree: RTL and testbench
=======================================

Name: pipelined_adder_tree

Overview:
Parametrised, fully pipelined successor to the combinational weight-sum adder tree. It reduces 2**N_STAGE lanes of IN_W-bit weighted inputs to one sum, with one register level per tree stage. Lanes are interpreted as signed or unsigned per beat. A saturating frame accumulator sits behind the tree and integrates multi-beat neuron inputs up to an in_last marker. The block sits between the synapse/weight-product logic and the neuron membrane update.

Parameters:
N_STAGE, 5, tree depth; lane count = 2**N_STAGE (>=1)
IN_W, 2, bits per lane (>=1)
ACC_W, 12, accumulator width (must be >= IN_W+N_STAGE)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
in_valid  input  1  beat present on wx this cycle; no backpressure
in_last  input  1  beat closes the current frame (qualified by in_valid)
mode_signed  input  1  1 = lanes two's-complement, 0 = unsigned (per beat)
wx  input  (2**N_STAGE)*IN_W  lane j at bits [j*IN_W +: IN_W]
sum_valid  output  1  sum holds a new tree result
sum  output  IN_W+N_STAGE  per-beat tree sum (S_W)
acc_valid  output  1  one-cycle pulse, frame result on acc_out
acc_out  output  ACC_W  saturated frame total, held until next acc_valid
acc_sat  output  1  saturation occurred in the frame just reported

Behaviour:
- Reset (clk edge with reset=1): all pipeline valid bits, sum, sum_valid, acc_valid, acc_out, acc_sat and the internal running accumulator are cleared to 0. The internal first-beat flag is set to 1. In-flight beats are discarded. in_valid is ignored on the reset cycle.
- Pipeline: stage 0 registers wx, in_last and mode_signed on an edge where in_valid=1. Stage k (1..N_STAGE) holds 2**(N_STAGE-k) partial sums of width IN_W+k. Each is formed from a pair of stage k-1 values, each extended by 1 bit: sign-extended if that beat's mode_signed=1, zero-extended otherwise.
- Valid, last and mode travel with the data through every stage. Bubbles (in_valid=0) propagate as invalid slots. Full throughput: one beat per cycle.
- Latency: a beat accepted on edge t drives sum/sum_valid on edge t+N_STAGE. Its accumulator effect shows on edge t+N_STAGE+1.
- Width: S_W=IN_W+N_STAGE never overflows. Unsigned range is 0..(2**IN_W-1)*2**N_STAGE. Signed range is -2**(S_W-1)..(2**(IN_W-1)-1)*2**N_STAGE.
- sum holds its last value while sum_valid=0.
- Accumulator: on each cycle with sum_valid=1, compute next = (first ? 0 : acc) + ext(sum), where ext sign- or zero-extends to ACC_W+1 using that beat's mode.
  - Clamp next to [0, 2**ACC_W-1] when unsigned, or [-2**(ACC_W-1), 2**(ACC_W-1)-1] when signed. Any clamp sets the internal sticky sat flag (cleared at frame start).
  - Each beat's add and clamp use that beat's own mode. Mixing modes within a frame is legal and deterministic.
  - first <= last of the beat.
  - If last=1: on the next edge, acc_out <= clamped value, acc_sat <= sticky OR this beat's clamp, acc_valid=1 for exactly one cycle.
  - A single-beat frame (first and last together) reports that beat's extended sum.
- Back-to-back frames: last on beat n and first of frame n+1 on the very next beat is legal. The new frame starts from 0, and acc_sat is not carried over.
- There are no idle-cycle side effects. A frame may contain bubbles between beats.

Test Plan:
1. Reset with in_valid=1 and random wx -> all outputs 0 for the reset cycle and after; nothing appears on sum_valid N_STAGE cycles later.
2. Defaults, unsigned, wx all ones (every lane 3), in_last=1, accepted edge t -> sum=96 and sum_valid at t+5; acc_out=96, acc_valid pulse and acc_sat=0 at t+6.
3. Signed, every lane 2'b10 (-2) -> sum=7'b1000000 (-64); single-beat frame gives acc_out=12'hFC0 (-64). Mixed lanes (16 at +1, 16 at -1) -> sum=0.
4. Three consecutive unsigned beats with sums 1, 2, 3, last on the third -> sum_valid high for 3 consecutive cycles; exactly one acc_valid pulse with acc_out=6. An immediate following single beat of sum 4 -> next acc_out=4.
5. Unsigned frame of 43 beats, each sum 96 -> after 42 beats the running value is 4032; acc_out=4095 with acc_sat=1. The following frame of one beat of sum 1 -> acc_out=1, acc_sat=0.
6. Reset asserted while 2 beats are in flight mid-frame, then a single-beat frame with sum 5 -> no stale sum_valid; acc_out=5, acc_sat=0.

Source files
------------

// File: rtl/pipelined_adder_tree.sv
// Pipelined adder tree: reduces 2**N_STAGE lanes of IN_W bits to one sum with
// one register level per tree stage, followed by a saturating frame accumulator
// that integrates beats up to an in_last marker.
module pipelined_adder_tree #(
    parameter int N_STAGE = 5,
    parameter int IN_W    = 2,
    parameter int ACC_W   = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic                            in_last,
    input  logic                            mode_signed,
    input  logic [(2**N_STAGE)*IN_W-1:0]    wx,
    output logic                            sum_valid,
    output logic [IN_W+N_STAGE-1:0]         sum,
    output logic                            acc_valid,
    output logic [ACC_W-1:0]                acc_out,
    output logic                            acc_sat
);

    localparam int LANES = 2**N_STAGE;
    localparam int S_W   = IN_W + N_STAGE;

    // Stage 0: raw lanes plus the beat's side-band bits.
    logic [LANES*IN_W-1:0] s0_data_r;
    logic                  s0_valid_r;
    logic                  s0_last_r;
    logic                  s0_mode_r;

    // Capture an accepted beat; bubbles only clear the valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_r <= 1'b0;
            s0_last_r  <= 1'b0;
            s0_mode_r  <= 1'b0;
            s0_data_r  <= '0;
        end else begin
            s0_valid_r <= in_valid;
            if (in_valid) begin
                s0_data_r <= wx;
                s0_last_r <= in_last;
                s0_mode_r <= mode_signed;
            end
        end
    end

    // Tree stages: stage k holds 2**(N_STAGE-k) partials of IN_W+k bits.
    for (genvar k = 1; k <= N_STAGE; k++) begin : g_stage
        localparam int CNT = 2**(N_STAGE - k);
        localparam int W   = IN_W + k;

        logic [CNT*W-1:0]       data_r;
        logic                   valid_r;
        logic                   last_r;
        logic                   mode_r;

        logic [2*CNT*(W-1)-1:0] prev_data_s;
        logic                   prev_valid_s;
        logic                   prev_last_s;
        logic                   prev_mode_s;
        logic [CNT*W-1:0]       sum_s;

        if (k == 1) begin : g_src_in
            assign prev_data_s  = s0_data_r;
            assign prev_valid_s = s0_valid_r;
            assign prev_last_s  = s0_last_r;
            assign prev_mode_s  = s0_mode_r;
        end else begin : g_src_tree
            assign prev_data_s  = g_stage[k-1].data_r;
            assign prev_valid_s = g_stage[k-1].valid_r;
            assign prev_last_s  = g_stage[k-1].last_r;
            assign prev_mode_s  = g_stage[k-1].mode_r;
        end

        // Pairwise add; each operand grows one bit using its beat's signedness.
        always_comb begin
            logic [W-2:0] lo_v;
            logic [W-2:0] hi_v;
            sum_s = '0;
            lo_v  = '0;
            hi_v  = '0;
            for (int j = 0; j < CNT; j++) begin
                lo_v = prev_data_s[(2*j)*(W-1) +: (W-1)];
                hi_v = prev_data_s[(2*j+1)*(W-1) +: (W-1)];
                sum_s[j*W +: W] = {prev_mode_s & lo_v[W-2], lo_v}
                                + {prev_mode_s & hi_v[W-2], hi_v};
            end
        end

        // Register the partials; data holds across bubbles so the last stage keeps sum.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_r <= 1'b0;
                last_r  <= 1'b0;
                mode_r  <= 1'b0;
                data_r  <= '0;
            end else begin
                valid_r <= prev_valid_s;
                if (prev_valid_s) begin
                    data_r <= sum_s;
                    last_r <= prev_last_s;
                    mode_r <= prev_mode_s;
                end
            end
        end
    end

    logic sum_last_s;
    logic sum_mode_s;

    assign sum        = g_stage[N_STAGE].data_r;
    assign sum_valid  = g_stage[N_STAGE].valid_r;
    assign sum_last_s = g_stage[N_STAGE].last_r;
    assign sum_mode_s = g_stage[N_STAGE].mode_r;

    // Frame accumulator state.
    logic [ACC_W-1:0] acc_r;
    logic             first_r;
    logic             sat_r;

    logic [ACC_W:0]   base_s;
    logic [ACC_W:0]   add_s;
    logic [ACC_W:0]   next_s;
    logic [ACC_W-1:0] clamp_s;
    logic             clip_s;
    logic             sat_in_s;

    // One-bit-wider add, then clamp into the beat's own numeric range.
    always_comb begin
        base_s   = '0;
        add_s    = {{(ACC_W+1-S_W){sum_mode_s & sum[S_W-1]}}, sum};
        next_s   = '0;
        clamp_s  = '0;
        clip_s   = 1'b0;
        sat_in_s = 1'b0;
        if (first_r) begin
            base_s   = '0;
            sat_in_s = 1'b0;
        end else begin
            base_s   = {sum_mode_s & acc_r[ACC_W-1], acc_r};
            sat_in_s = sat_r;
        end
        next_s = base_s + add_s;
        if (sum_mode_s) begin
            if (next_s[ACC_W] != next_s[ACC_W-1]) begin
                clip_s  = 1'b1;
                clamp_s = next_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                clip_s  = 1'b0;
                clamp_s = next_s[ACC_W-1:0];
            end
        end else begin
            if (next_s[ACC_W]) begin
                clip_s  = 1'b1;
                clamp_s = {ACC_W{1'b1}};
            end else begin
                clip_s  = 1'b0;
                clamp_s = next_s[ACC_W-1:0];
            end
        end
    end

    // Integrate each valid tree result; publish and restart on the frame's last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r     <= '0;
            first_r   <= 1'b1;
            sat_r     <= 1'b0;
            acc_valid <= 1'b0;
            acc_out   <= '0;
            acc_sat   <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            if (sum_valid) begin
                acc_r   <= clamp_s;
                first_r <= sum_last_s;
                sat_r   <= sat_in_s | clip_s;
                if (sum_last_s) begin
                    acc_out   <= clamp_s;
                    acc_sat   <= sat_in_s | clip_s;
                    acc_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed self-checking bench for pipelined_adder_tree (default parameters).
module tb_pipelined_adder_tree;

    localparam int N_STAGE = 5;
    localparam int IN_W    = 2;
    localparam int ACC_W   = 12;
    localparam int LANES   = 2**N_STAGE;
    localparam int S_W     = IN_W + N_STAGE;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_last;
    logic                   mode_signed;
    logic [LANES*IN_W-1:0]  wx;
    logic                   sum_valid;
    logic [S_W-1:0]         sum;
    logic                   acc_valid;
    logic [ACC_W-1:0]       acc_out;
    logic                   acc_sat;

    int checks = 0;
    int errors = 0;

    pipelined_adder_tree #(.N_STAGE(N_STAGE), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .mode_signed(mode_signed),
        .wx         (wx),
        .sum_valid  (sum_valid),
        .sum        (sum),
        .acc_valid  (acc_valid),
        .acc_out    (acc_out),
        .acc_sat    (acc_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All lanes carry the same value.
    function automatic logic [LANES*IN_W-1:0] all_lanes(input logic [IN_W-1:0] v);
        logic [LANES*IN_W-1:0] r;
        r = '0;
        for (int j = 0; j < LANES; j++) r[j*IN_W +: IN_W] = v;
        return r;
    endfunction

    // Lanes 0..n-1 = 1, rest 0: unsigned sum n.
    function automatic logic [LANES*IN_W-1:0] ones(input int n);
        logic [LANES*IN_W-1:0] r;
        r = '0;
        for (int j = 0; j < n; j++) r[j*IN_W +: IN_W] = 2'b01;
        return r;
    endfunction

    task automatic beat(input logic [LANES*IN_W-1:0] w, input logic last, input logic sgn);
        in_valid    = 1'b1;
        wx          = w;
        in_last     = last;
        mode_signed = sgn;
        tick();
        in_valid    = 1'b0;
        in_last     = 1'b0;
    endtask

    initial begin
        logic [LANES*IN_W-1:0] mixed;

        // 1: reset with live input must swallow the beat
        reset       = 1'b1;
        in_valid    = 1'b1;
        in_last     = 1'b1;
        mode_signed = 1'b0;
        wx          = {$urandom, $urandom};
        tick();
        check("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
        check("rst_sum", {25'd0, sum}, 32'd0);
        check("rst_acc_valid", {31'd0, acc_valid}, 32'd0);
        check("rst_acc_out", {20'd0, acc_out}, 32'd0);
        check("rst_acc_sat", {31'd0, acc_sat}, 32'd0);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < N_STAGE + 2; i++) begin
            tick();
            check("rst_no_sum_valid", {31'd0, sum_valid}, 32'd0);
            check("rst_no_acc_valid", {31'd0, acc_valid}, 32'd0);
        end

        // 2: unsigned all-3 single-beat frame, latency t+5 / t+6
        beat(all_lanes(2'b11), 1'b1, 1'b0);
        for (int i = 1; i < N_STAGE; i++) begin
            tick();
            check("t2_latency_sv", {31'd0, sum_valid}, 32'd0);
        end
        tick();
        check("t2_sum_valid", {31'd0, sum_valid}, 32'd1);
        check("t2_sum", {25'd0, sum}, 32'd96);
        check("t2_acc_valid_early", {31'd0, acc_valid}, 32'd0);
        tick();
        check("t2_sum_valid_drop", {31'd0, sum_valid}, 32'd0);
        check("t2_sum_hold", {25'd0, sum}, 32'd96);
        check("t2_acc_valid", {31'd0, acc_valid}, 32'd1);
        check("t2_acc_out", {20'd0, acc_out}, 32'd96);
        check("t2_acc_sat", {31'd0, acc_sat}, 32'd0);
        tick();
        check("t2_acc_pulse", {31'd0, acc_valid}, 32'd0);
        check("t2_acc_hold", {20'd0, acc_out}, 32'd96);

        // 3: signed all -2, then mixed +1/-1 lanes
        mixed = all_lanes(2'b11);
        for (int j = 0; j < LANES/2; j++) mixed[j*IN_W +: IN_W] = 2'b01;
        beat(all_lanes(2'b10), 1'b1, 1'b1);
        beat(mixed, 1'b1, 1'b1);
        for (int i = 2; i < N_STAGE; i++) tick();
        tick();
        check("t3_neg_sum", {25'd0, sum}, 32'h40);
        check("t3_neg_sv", {31'd0, sum_valid}, 32'd1);
        tick();
        check("t3_mixed_sum", {25'd0, sum}, 32'd0);
        check("t3_neg_acc_valid", {31'd0, acc_valid}, 32'd1);
        check("t3_neg_acc", {20'd0, acc_out}, 32'hFC0);
        check("t3_neg_sat", {31'd0, acc_sat}, 32'd0);
        tick();
        check("t3_mixed_acc_valid", {31'd0, acc_valid}, 32'd1);
        check("t3_mixed_acc", {20'd0, acc_out}, 32'd0);
        tick();

        // 4: frame of 1,2,3 then immediate single beat of 4
        beat(ones(1), 1'b0, 1'b0);
        beat(ones(2), 1'b0, 1'b0);
        beat(ones(3), 1'b1, 1'b0);
        beat(ones(4), 1'b1, 1'b0);
        tick();
        check("t4_pre_sv", {31'd0, sum_valid}, 32'd0);
        tick();
        check("t4_sum1", {25'd0, sum}, 32'd1);
        check("t4_sv1", {31'd0, sum_valid}, 32'd1);
        tick();
        check("t4_sum2", {25'd0, sum}, 32'd2);
        check("t4_sv2", {31'd0, sum_valid}, 32'd1);
        check("t4_no_acc2", {31'd0, acc_valid}, 32'd0);
        tick();
        check("t4_sum3", {25'd0, sum}, 32'd3);
        check("t4_sv3", {31'd0, sum_valid}, 32'd1);
        check("t4_no_acc3", {31'd0, acc_valid}, 32'd0);
        tick();
        check("t4_sum4", {25'd0, sum}, 32'd4);
        check("t4_acc_valid", {31'd0, acc_valid}, 32'd1);
        check("t4_acc6", {20'd0, acc_out}, 32'd6);
        tick();
        check("t4_sv_end", {31'd0, sum_valid}, 32'd0);
        check("t4_acc_valid4", {31'd0, acc_valid}, 32'd1);
        check("t4_acc4", {20'd0, acc_out}, 32'd4);
        tick();
        check("t4_acc_pulse", {31'd0, acc_valid}, 32'd0);

        // 5: 43 beats of 96 saturate, then a clean 1-beat frame
        for (int i = 0; i < 43; i++) beat(all_lanes(2'b11), (i == 42), 1'b0);
        beat(ones(1), 1'b1, 1'b0);
        for (int i = 0; i < N_STAGE - 1; i++) begin
            tick();
            check("t5_no_early_acc", {31'd0, acc_valid}, 32'd0);
        end
        tick();
        check("t5_acc_valid", {31'd0, acc_valid}, 32'd1);
        check("t5_acc_sat_val", {20'd0, acc_out}, 32'hFFF);
        check("t5_acc_sat", {31'd0, acc_sat}, 32'd1);
        tick();
        check("t5_next_valid", {31'd0, acc_valid}, 32'd1);
        check("t5_next_acc", {20'd0, acc_out}, 32'd1);
        check("t5_next_sat", {31'd0, acc_sat}, 32'd0);
        tick();

        // 6: reset mid-frame with two beats in flight
        beat(all_lanes(2'b11), 1'b0, 1'b0);
        beat(all_lanes(2'b11), 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_acc_out", {20'd0, acc_out}, 32'd0);
        check("t6_rst_sv", {31'd0, sum_valid}, 32'd0);
        beat(ones(5), 1'b1, 1'b0);
        for (int i = 1; i < N_STAGE; i++) begin
            tick();
            check("t6_no_stale_sv", {31'd0, sum_valid}, 32'd0);
        end
        tick();
        check("t6_sum", {25'd0, sum}, 32'd5);
        check("t6_sv", {31'd0, sum_valid}, 32'd1);
        tick();
        check("t6_acc_valid", {31'd0, acc_valid}, 32'd1);
        check("t6_acc_out", {20'd0, acc_out}, 32'd5);
        check("t6_acc_sat", {31'd0, acc_sat}, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
